// File: rtl/otbn_vec_pkg.sv
// Shared constants, sequencer state encoding and lane helper for the vector
// modular-add sequencer.
package otbn_vec_pkg;

  localparam int DataWidth = 32;
  localparam int VecWidth  = 256;

  typedef enum logic [1:0] {
    VecSeqIdle = 2'd0,
    VecSeqRun  = 2'd1,
    VecSeqDone = 2'd2
  } vec_seq_state_e;

  // Extract lane k of a default-width vector.
  function automatic logic [DataWidth-1:0] lane_sel(input logic [VecWidth-1:0] vec,
                                                    input int unsigned k);
    return vec[k*DataWidth +: DataWidth];
  endfunction

endpackage

// File: rtl/otbn_adder.sv
// Single-lane modular adder: (a + b) mod 2^Width, minus q once if the result is >= q.
module otbn_adder #(
  parameter int Width = 32
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic [Width-1:0] q_i,
  output logic [Width-1:0] sum_o
);

  logic [Width-1:0] raw_s;

  // Wrapping sum followed by a single conditional subtraction of the modulus.
  always_comb begin
    raw_s = a_i + b_i;
    if (raw_s >= q_i) begin
      sum_o = raw_s - q_i;
    end else begin
      sum_o = raw_s;
    end
  end

endmodule

// File: rtl/otbn_vec_addmod_seq.sv
// Runs one shared otbn_adder over every lane of a vector pair, one lane per cycle.
// Optional modular subtraction when OTBN_VEC_ADDMOD_SUB_EN is defined.
module otbn_vec_addmod_seq
  import otbn_vec_pkg::*;
#(
  parameter int DATA_WIDTH = DataWidth,
  parameter int VEC_WIDTH  = VecWidth
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [VEC_WIDTH-1:0]  vec_a_i,
  input  logic [VEC_WIDTH-1:0]  vec_b_i,
  input  logic [DATA_WIDTH-1:0] q_i,
`ifdef OTBN_VEC_ADDMOD_SUB_EN
  input  logic                  op_sub_i,
`endif
  input  logic                  clear_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [VEC_WIDTH-1:0]  vec_res_o,
  output logic                  busy_o
);

  localparam int NLANES = VEC_WIDTH / DATA_WIDTH;
  localparam int CntW   = (NLANES > 1) ? $clog2(NLANES) : 1;
  localparam logic [CntW-1:0] LastLane = CntW'(NLANES - 1);

  if ((VEC_WIDTH % DATA_WIDTH) != 0) begin : g_width_check
    $error("VEC_WIDTH must be an integer multiple of DATA_WIDTH");
  end

  vec_seq_state_e        state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [VEC_WIDTH-1:0]  a_q, b_q, res_q;
  logic [DATA_WIDTH-1:0] q_q;
  logic                  valid_q, ready_q, busy_q;
  logic                  load_s, wr_s;
  logic [DATA_WIDTH-1:0] a_lane_s, b_lane_s, b_eff_s, sum_s;

  // Next-state, lane counter and load/write strobes; clear_i overrides everything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load_s  = 1'b0;
    wr_s    = 1'b0;
    if (clear_i) begin
      state_d = VecSeqIdle;
      cnt_d   = {CntW{1'b0}};
    end else begin
      case (state_q)
        VecSeqIdle: begin
          if (valid_i) begin
            state_d = VecSeqRun;
            cnt_d   = {CntW{1'b0}};
            load_s  = 1'b1;
          end else begin
            state_d = VecSeqIdle;
          end
        end
        VecSeqRun: begin
          wr_s = 1'b1;
          if (cnt_q == LastLane) begin
            state_d = VecSeqDone;
            cnt_d   = {CntW{1'b0}};
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        VecSeqDone: begin
          if (ready_i) begin
            state_d = VecSeqIdle;
          end else begin
            state_d = VecSeqDone;
          end
        end
        default: begin
          state_d = VecSeqIdle;
          cnt_d   = {CntW{1'b0}};
        end
      endcase
    end
  end

  assign a_lane_s = a_q[cnt_q*DATA_WIDTH +: DATA_WIDTH];
  assign b_lane_s = b_q[cnt_q*DATA_WIDTH +: DATA_WIDTH];

`ifdef OTBN_VEC_ADDMOD_SUB_EN
  logic sub_q;

  // Subtraction reuses the adder: a - b == a + (q - b) mod q.
  always_comb begin
    if (sub_q) begin
      b_eff_s = q_q - b_lane_s;
    end else begin
      b_eff_s = b_lane_s;
    end
  end

  // Operation select captured at accept.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sub_q <= 1'b0;
    end else if (load_s) begin
      sub_q <= op_sub_i;
    end else begin
      sub_q <= sub_q;
    end
  end
`else
  assign b_eff_s = b_lane_s;
`endif

  otbn_adder #(
    .Width(DATA_WIDTH)
  ) u_adder (
    .a_i  (a_lane_s),
    .b_i  (b_eff_s),
    .q_i  (q_q),
    .sum_o(sum_s)
  );

  // State, operand capture, per-lane result write and registered handshake outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= VecSeqIdle;
      cnt_q   <= {CntW{1'b0}};
      a_q     <= {VEC_WIDTH{1'b0}};
      b_q     <= {VEC_WIDTH{1'b0}};
      q_q     <= {DATA_WIDTH{1'b0}};
      res_q   <= {VEC_WIDTH{1'b0}};
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load_s) begin
        a_q <= vec_a_i;
        b_q <= vec_b_i;
        q_q <= q_i;
      end
      if (wr_s) begin
        res_q[cnt_q*DATA_WIDTH +: DATA_WIDTH] <= sum_s;
      end
      valid_q <= (state_d == VecSeqDone);
      ready_q <= (state_d == VecSeqIdle);
      busy_q  <= (state_d != VecSeqIdle);
    end
  end

  assign valid_o   = valid_q;
  assign ready_o   = ready_q;
  assign busy_o    = busy_q;
  assign vec_res_o = res_q;

endmodule

// File: tb/tb_otbn_vec_addmod_seq.sv
// Directed self-checking bench for otbn_vec_addmod_seq (default 8 x 32-bit lanes).
// Exercises the subtract path too when OTBN_VEC_ADDMOD_SUB_EN is defined.
module tb_otbn_vec_addmod_seq;
  import otbn_vec_pkg::*;

  localparam int NL = VecWidth / DataWidth;

  logic                 clk;
  logic                 rst_ni;
  logic                 valid_i, ready_o, clear_i, valid_o, ready_i, busy_o;
  logic [VecWidth-1:0]  vec_a_i, vec_b_i, vec_res_o;
  logic [DataWidth-1:0] q_i;
  logic                 op_sub_i;

  int n_tests;
  int n_fail;

  otbn_vec_addmod_seq dut (
    .clk_i    (clk),
    .rst_ni   (rst_ni),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .vec_a_i  (vec_a_i),
    .vec_b_i  (vec_b_i),
    .q_i      (q_i),
`ifdef OTBN_VEC_ADDMOD_SUB_EN
    .op_sub_i (op_sub_i),
`endif
    .clear_i  (clear_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .vec_res_o(vec_res_o),
    .busy_o   (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [VecWidth-1:0] splat(input logic [DataWidth-1:0] v);
    logic [VecWidth-1:0] r;
    for (int k = 0; k < NL; k++) r[k*DataWidth +: DataWidth] = v;
    return r;
  endfunction

  // Present a request for exactly one accepting edge (DUT must be in IDLE).
  task automatic send(input logic [VecWidth-1:0] a, input logic [VecWidth-1:0] b,
                      input logic [DataWidth-1:0] q);
    vec_a_i = a;
    vec_b_i = b;
    q_i     = q;
    valid_i = 1'b1;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
  endtask

  // Count edges until valid_o; -1 on timeout.
  task automatic wait_valid(output int cycles);
    cycles = 0;
    while (!valid_o && cycles < 30) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    if (!valid_o) cycles = -1;
  endtask

  task automatic test_reset();
    n_tests++;
    if (ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b exp 1", ready_o); end
    n_tests++;
    if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b exp 0", valid_o); end
    n_tests++;
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b exp 0", busy_o); end
    n_tests++;
    if (vec_res_o !== '0) begin n_fail++; $display("FAIL reset_res: got %h exp 0", vec_res_o); end
  endtask

  task automatic test_wrap();
    int lat;
    ready_i = 1'b1;
    send(splat(32'd3328), splat(32'd1), 32'd3329);
    wait_valid(lat);
    n_tests++;
    if (lat !== 8) begin n_fail++; $display("FAIL wrap_latency: got %0d exp 8", lat); end
    n_tests++;
    if (vec_res_o !== splat(32'd0)) begin n_fail++; $display("FAIL wrap_res: got %h exp %h", vec_res_o, splat(32'd0)); end
    n_tests++;
    if (lane_sel(vec_res_o, 7) !== 32'd0) begin n_fail++; $display("FAIL wrap_lane7: got %0d exp 0", lane_sel(vec_res_o, 7)); end
    @(posedge clk);
    #1;
    n_tests++;
    if (valid_o !== 1'b0) begin n_fail++; $display("FAIL wrap_valid_pulse: got %b exp 0", valid_o); end
    n_tests++;
    if (ready_o !== 1'b1) begin n_fail++; $display("FAIL wrap_ready_after: got %b exp 1", ready_o); end
  endtask

  task automatic test_no_reduce();
    int lat;
    logic [VecWidth-1:0] a, e;
    for (int k = 0; k < NL; k++) begin
      a[k*DataWidth +: DataWidth] = DataWidth'(k);
      e[k*DataWidth +: DataWidth] = DataWidth'(100 + k);
    end
    send(a, splat(32'd100), 32'd3329);
    wait_valid(lat);
    n_tests++;
    if (lat !== 8) begin n_fail++; $display("FAIL noreduce_latency: got %0d exp 8", lat); end
    n_tests++;
    if (vec_res_o !== e) begin n_fail++; $display("FAIL noreduce_res: got %h exp %h", vec_res_o, e); end
    @(posedge clk);
    #1;
    send(splat(32'd3000), splat(32'd3000), 32'd3329);
    wait_valid(lat);
    n_tests++;
    if (lat !== 8) begin n_fail++; $display("FAIL reduce_latency: got %0d exp 8", lat); end
    n_tests++;
    if (vec_res_o !== splat(32'd2671)) begin n_fail++; $display("FAIL reduce_res: got %h exp %h", vec_res_o, splat(32'd2671)); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    int lat;
    ready_i = 1'b0;
    send(splat(32'd3000), splat(32'd329), 32'd3329);
    wait_valid(lat);
    n_tests++;
    if (lat !== 8) begin n_fail++; $display("FAIL bp_latency: got %0d exp 8", lat); end
    for (int i = 0; i < 5; i++) begin
      valid_i = ~valid_i;
      vec_a_i = splat(DataWidth'(i + 1));
      vec_b_i = splat(32'd7);
      q_i     = 32'd11;
      @(posedge clk);
      #1;
      n_tests++;
      if (vec_res_o !== splat(32'd0)) begin n_fail++; $display("FAIL bp_res_hold[%0d]: got %h exp 0", i, vec_res_o); end
      n_tests++;
      if (valid_o !== 1'b1) begin n_fail++; $display("FAIL bp_valid_hold[%0d]: got %b exp 1", i, valid_o); end
      n_tests++;
      if (ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_ready_hold[%0d]: got %b exp 0", i, ready_o); end
    end
    vec_a_i = splat(32'd1);
    vec_b_i = splat(32'd2);
    q_i     = 32'd3329;
    valid_i = 1'b1;
    ready_i = 1'b1;
    @(posedge clk);
    #1;
    n_tests++;
    if (valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid: got %b exp 0", valid_o); end
    n_tests++;
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL bp_no_reaccept: got %b exp 0", busy_o); end
    n_tests++;
    if (ready_o !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b exp 1", ready_o); end
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    n_tests++;
    if (busy_o !== 1'b1) begin n_fail++; $display("FAIL bp_accept_busy: got %b exp 1", busy_o); end
    wait_valid(lat);
    n_tests++;
    if (lat !== 8) begin n_fail++; $display("FAIL bp_next_latency: got %0d exp 8", lat); end
    n_tests++;
    if (vec_res_o !== splat(32'd3)) begin n_fail++; $display("FAIL bp_next_res: got %h exp %h", vec_res_o, splat(32'd3)); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_clear();
    int lat;
    send(splat(32'd10), splat(32'd20), 32'd3329);
    repeat (3) @(posedge clk);
    #1;
    clear_i = 1'b1;
    @(posedge clk);
    #1;
    clear_i = 1'b0;
    n_tests++;
    if (ready_o !== 1'b1) begin n_fail++; $display("FAIL clear_ready: got %b exp 1", ready_o); end
    n_tests++;
    if (valid_o !== 1'b0) begin n_fail++; $display("FAIL clear_valid: got %b exp 0", valid_o); end
    n_tests++;
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL clear_busy: got %b exp 0", busy_o); end
    send(splat(32'd7680), splat(32'd2), 32'd7681);
    wait_valid(lat);
    n_tests++;
    if (lat !== 8) begin n_fail++; $display("FAIL clear_next_latency: got %0d exp 8", lat); end
    n_tests++;
    if (vec_res_o !== splat(32'd1)) begin n_fail++; $display("FAIL clear_next_res: got %h exp %h", vec_res_o, splat(32'd1)); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_async_reset();
    int lat;
    send(splat(32'd5), splat(32'd6), 32'd3329);
    repeat (3) @(posedge clk);
    #2;
    rst_ni = 1'b0;
    #1;
    n_tests++;
    if (ready_o !== 1'b1) begin n_fail++; $display("FAIL arst_ready: got %b exp 1", ready_o); end
    n_tests++;
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL arst_busy: got %b exp 0", busy_o); end
    n_tests++;
    if (vec_res_o !== '0) begin n_fail++; $display("FAIL arst_res: got %h exp 0", vec_res_o); end
    #2;
    rst_ni = 1'b1;
    send(splat(32'd1000), splat(32'd2000), 32'd3329);
    wait_valid(lat);
    n_tests++;
    if (lat !== 8) begin n_fail++; $display("FAIL arst_next_latency: got %0d exp 8", lat); end
    n_tests++;
    if (vec_res_o !== splat(32'd3000)) begin n_fail++; $display("FAIL arst_next_res: got %h exp %h", vec_res_o, splat(32'd3000)); end
    @(posedge clk);
    #1;
  endtask

`ifdef OTBN_VEC_ADDMOD_SUB_EN
  task automatic test_sub();
    int lat;
    op_sub_i = 1'b1;
    send(splat(32'd5), splat(32'd10), 32'd3329);
    op_sub_i = 1'b0;
    wait_valid(lat);
    n_tests++;
    if (lat !== 8) begin n_fail++; $display("FAIL sub_latency: got %0d exp 8", lat); end
    n_tests++;
    if (vec_res_o !== splat(32'd3324)) begin n_fail++; $display("FAIL sub_res: got %h exp %h", vec_res_o, splat(32'd3324)); end
    @(posedge clk);
    #1;
    op_sub_i = 1'b1;
    send(splat(32'd5), splat(32'd0), 32'd3329);
    op_sub_i = 1'b0;
    wait_valid(lat);
    n_tests++;
    if (vec_res_o !== splat(32'd5)) begin n_fail++; $display("FAIL sub_b0_res: got %h exp %h", vec_res_o, splat(32'd5)); end
    @(posedge clk);
    #1;
    send(splat(32'd5), splat(32'd10), 32'd3329);
    wait_valid(lat);
    n_tests++;
    if (vec_res_o !== splat(32'd15)) begin n_fail++; $display("FAIL sub_off_res: got %h exp %h", vec_res_o, splat(32'd15)); end
    @(posedge clk);
    #1;
  endtask
`endif

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst_ni   = 1'b0;
    valid_i  = 1'b0;
    ready_i  = 1'b1;
    clear_i  = 1'b0;
    op_sub_i = 1'b0;
    vec_a_i  = '0;
    vec_b_i  = '0;
    q_i      = '0;
    #12;
    test_reset();
    #1;
    rst_ni = 1'b1;
    @(posedge clk);
    #1;
    test_wrap();
    test_no_reduce();
    test_backpressure();
    test_clear();
    test_async_reset();
`ifdef OTBN_VEC_ADDMOD_SUB_EN
    test_sub();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
